// File: rtl/fifo_side_ptr.sv
// One side of an asynchronous FIFO pointer pair: binary/Gray pointer with wrap bit, remote
// pointer synchroniser, registered full/empty, almost flag, occupancy and sticky misuse error.
module fifo_side_ptr #(
   parameter int unsigned ADDR_W      = 4,
   parameter bit          IS_WRITE    = 1'b1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ALMOST_TH   = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              inc_en_i,
   input  logic [ADDR_W:0]   remote_gray_i,
   output logic              inc_ok_o,
   output logic [ADDR_W-1:0] bin_ptr_o,
   output logic [ADDR_W:0]   gray_ptr_o,
   output logic              flag_o,
   output logic              almost_o,
   output logic [ADDR_W:0]   level_o,
   output logic              err_o
);

   localparam int unsigned     Depth      = 1 << ADDR_W;
   localparam logic [ADDR_W:0] AlmostFull = (ADDR_W+1)'(Depth - ALMOST_TH);
   localparam logic [ADDR_W:0] AlmostTh   = (ADDR_W+1)'(ALMOST_TH);

   logic [ADDR_W:0] bin_q, bin_d;
   logic [ADDR_W:0] gray_q, gray_d;
   logic [ADDR_W:0] level_q, level_d;
   logic            flag_q, flag_d;
   logic            almost_q, almost_d;
   logic            err_q, err_d;
   logic [ADDR_W:0] sync_q [SYNC_STAGES];
   logic [ADDR_W:0] rsync;
   logic [ADDR_W:0] rbin;
   logic [ADDR_W:0] full_gray;

   function automatic logic [ADDR_W:0] gray2bin(input logic [ADDR_W:0] g);
      logic [ADDR_W:0] b;
      b[ADDR_W] = g[ADDR_W];
      for (int i = int'(ADDR_W) - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   assign rsync     = sync_q[SYNC_STAGES-1];
   assign rbin      = gray2bin(rsync);
   // Full when the pointers differ only in the two MSBs of their Gray codes.
   assign full_gray = {~rsync[ADDR_W:ADDR_W-1], rsync[ADDR_W-2:0]};

   assign inc_ok_o = inc_en_i & ~flag_q & ~rst_i;

   always_comb begin
      bin_d  = bin_q + {{ADDR_W{1'b0}}, inc_ok_o};
      gray_d = bin_d ^ (bin_d >> 1);
      err_d  = err_q | (inc_en_i & flag_q);
      if (IS_WRITE) begin
         flag_d   = (gray_d == full_gray);
         level_d  = bin_d - rbin;
         almost_d = (level_d >= AlmostFull);
      end else begin
         flag_d   = (gray_d == rsync);
         level_d  = rbin - bin_d;
         almost_d = (level_d <= AlmostTh);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= remote_gray_i;
         for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   // Read side comes out of reset empty, write side not full.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         bin_q    <= '0;
         gray_q   <= '0;
         level_q  <= '0;
         flag_q   <= ~IS_WRITE;
         almost_q <= ~IS_WRITE;
         err_q    <= 1'b0;
      end else begin
         bin_q    <= bin_d;
         gray_q   <= gray_d;
         level_q  <= level_d;
         flag_q   <= flag_d;
         almost_q <= almost_d;
         err_q    <= err_d;
      end
   end

   assign bin_ptr_o  = bin_q[ADDR_W-1:0];
   assign gray_ptr_o = gray_q;
   assign flag_o     = flag_q;
   assign almost_o   = almost_q;
   assign level_o    = level_q;
   assign err_o      = err_q;

endmodule

// File: tb/tb_fifo_side_ptr.sv
// Bench for fifo_side_ptr: write-side and read-side instances against an occupancy model,
// expected values queued per cycle and compared after each clock edge.
module tb_fifo_side_ptr;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       wr_rst, wr_en, wr_ok, wr_flag, wr_almost, wr_err;
   logic [4:0] wr_rg, wr_gray, wr_level;
   logic [3:0] wr_bptr;
   logic       rd_rst, rd_en, rd_ok, rd_flag, rd_almost, rd_err;
   logic [4:0] rd_rg, rd_gray, rd_level;
   logic [3:0] rd_bptr;

   fifo_side_ptr #(.ADDR_W(4), .IS_WRITE(1'b1), .SYNC_STAGES(2), .ALMOST_TH(2)) u_wr (
      .clk_i(clk), .rst_i(wr_rst), .inc_en_i(wr_en), .remote_gray_i(wr_rg),
      .inc_ok_o(wr_ok), .bin_ptr_o(wr_bptr), .gray_ptr_o(wr_gray), .flag_o(wr_flag),
      .almost_o(wr_almost), .level_o(wr_level), .err_o(wr_err)
   );

   fifo_side_ptr #(.ADDR_W(4), .IS_WRITE(1'b0), .SYNC_STAGES(2), .ALMOST_TH(2)) u_rd (
      .clk_i(clk), .rst_i(rd_rst), .inc_en_i(rd_en), .remote_gray_i(rd_rg),
      .inc_ok_o(rd_ok), .bin_ptr_o(rd_bptr), .gray_ptr_o(rd_gray), .flag_o(rd_flag),
      .almost_o(rd_almost), .level_o(rd_level), .err_o(rd_err)
   );

   typedef struct packed {
      logic [3:0] bptr;
      logic [4:0] gray;
      logic       flag;
      logic       almost;
      logic [4:0] level;
      logic       err;
   } exp_t;

   exp_t sb_wr[$];
   exp_t sb_rd[$];
   int   n_checks = 0;
   int   n_errors = 0;

   // Model state: index 0 = write side, 1 = read side; remote pointers held in binary.
   int   m_bin [2];
   int   m_s0  [2];
   int   m_s1  [2];
   logic m_flag[2];
   logic m_err [2];

   logic w_rst, w_en, r_rst, r_en;
   int   w_rb, r_rb;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] to_gray(input int b);
      return 5'(b ^ (b >> 1));
   endfunction

   task automatic model_step(input int s, input logic rst, input logic en, input int rb,
                             output exp_t e, output logic acc);
      int lvl;
      if (rst) begin
         m_bin[s]  = 0;
         m_s0[s]   = 0;
         m_s1[s]   = 0;
         m_err[s]  = 1'b0;
         m_flag[s] = (s == 1);
         e.almost  = (s == 1);
         lvl       = 0;
         acc       = 1'b0;
      end else begin
         acc       = en && !m_flag[s];
         m_err[s]  = m_err[s] | (en && m_flag[s]);
         m_bin[s]  = (m_bin[s] + int'(acc)) & 31;
         lvl       = (s == 0) ? ((m_bin[s] - m_s1[s]) & 31) : ((m_s1[s] - m_bin[s]) & 31);
         m_s1[s]   = m_s0[s];
         m_s0[s]   = rb;
         m_flag[s] = (s == 0) ? (lvl == 16) : (lvl == 0);
         e.almost  = (s == 0) ? (lvl >= 14) : (lvl <= 2);
      end
      e.bptr  = 4'(m_bin[s]);
      e.gray  = to_gray(m_bin[s]);
      e.flag  = m_flag[s];
      e.level = 5'(lvl);
      e.err   = m_err[s];
   endtask

   // Drive one cycle on both sides, check inc_ok, then compare registered outputs after the edge.
   task automatic tick();
      exp_t ew, er;
      logic aw, ar;
      wr_rst = w_rst;
      wr_en  = w_en;
      wr_rg  = to_gray(w_rb);
      rd_rst = r_rst;
      rd_en  = r_en;
      rd_rg  = to_gray(r_rb);
      model_step(0, w_rst, w_en, w_rb, ew, aw);
      model_step(1, r_rst, r_en, r_rb, er, ar);
      sb_wr.push_back(ew);
      sb_rd.push_back(er);
      #1;
      check_val("wr_inc_ok", {31'd0, wr_ok}, {31'd0, aw});
      check_val("rd_inc_ok", {31'd0, rd_ok}, {31'd0, ar});
      @(posedge clk);
      #1;
      ew = sb_wr.pop_front();
      check_val("wr_bin_ptr", {28'd0, wr_bptr}, {28'd0, ew.bptr});
      check_val("wr_gray_ptr", {27'd0, wr_gray}, {27'd0, ew.gray});
      check_val("wr_flag", {31'd0, wr_flag}, {31'd0, ew.flag});
      check_val("wr_almost", {31'd0, wr_almost}, {31'd0, ew.almost});
      check_val("wr_level", {27'd0, wr_level}, {27'd0, ew.level});
      check_val("wr_err", {31'd0, wr_err}, {31'd0, ew.err});
      er = sb_rd.pop_front();
      check_val("rd_bin_ptr", {28'd0, rd_bptr}, {28'd0, er.bptr});
      check_val("rd_gray_ptr", {27'd0, rd_gray}, {27'd0, er.gray});
      check_val("rd_flag", {31'd0, rd_flag}, {31'd0, er.flag});
      check_val("rd_almost", {31'd0, rd_almost}, {31'd0, er.almost});
      check_val("rd_level", {27'd0, rd_level}, {27'd0, er.level});
      check_val("rd_err", {31'd0, rd_err}, {31'd0, er.err});
   endtask

   initial begin
      logic [4:0] prev_gray;
      logic [3:0] prev_bptr;

      w_rst = 1'b1; w_en = 1'b1; w_rb = 0;
      r_rst = 1'b1; r_en = 1'b0; r_rb = 0;
      @(posedge clk);
      #1;
      tick();
      tick();
      check_val("rst_bin_ptr", {28'd0, wr_bptr}, 32'd0);
      check_val("rst_gray_ptr", {27'd0, wr_gray}, 32'd0);
      check_val("rst_flag", {31'd0, wr_flag}, 32'd0);
      check_val("rst_almost", {31'd0, wr_almost}, 32'd0);
      check_val("rst_level", {27'd0, wr_level}, 32'd0);
      check_val("rst_err", {31'd0, wr_err}, 32'd0);
      check_val("rst_rd_flag", {31'd0, rd_flag}, 32'd1);
      check_val("rst_rd_almost", {31'd0, rd_almost}, 32'd1);

      // Fill the write side against a stationary read pointer.
      w_rst = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 13) check_val("fill_almost_13", {31'd0, wr_almost}, 32'd0);
         if (i == 14) check_val("fill_almost_14", {31'd0, wr_almost}, 32'd1);
      end
      check_val("full_flag", {31'd0, wr_flag}, 32'd1);
      check_val("full_level", {27'd0, wr_level}, 32'd16);
      check_val("full_gray", {27'd0, wr_gray}, 32'b11000);
      check_val("full_bin_ptr", {28'd0, wr_bptr}, 32'd0);
      check_val("full_block_ok", {31'd0, wr_ok}, 32'd0);
      tick();
      check_val("block_gray", {27'd0, wr_gray}, 32'b11000);
      check_val("block_err", {31'd0, wr_err}, 32'd1);

      // Remote read pointer advances to 4: visible two edges after the first capturing edge.
      w_en = 1'b0;
      w_rb = 4;
      tick();
      check_val("drain_flag_e1", {31'd0, wr_flag}, 32'd1);
      tick();
      check_val("drain_flag_e2", {31'd0, wr_flag}, 32'd1);
      tick();
      check_val("drain_flag_e3", {31'd0, wr_flag}, 32'd0);
      check_val("drain_level", {27'd0, wr_level}, 32'd12);
      check_val("drain_almost", {31'd0, wr_almost}, 32'd0);

      // Reset in the middle of operation with level 9 and err set.
      w_rb = 7;
      tick(); tick(); tick();
      check_val("pre_rst_level", {27'd0, wr_level}, 32'd9);
      check_val("pre_rst_err", {31'd0, wr_err}, 32'd1);
      w_rst = 1'b1;
      w_en  = 1'b1;
      tick();
      check_val("mid_rst_bin_ptr", {28'd0, wr_bptr}, 32'd0);
      check_val("mid_rst_gray", {27'd0, wr_gray}, 32'd0);
      check_val("mid_rst_flag", {31'd0, wr_flag}, 32'd0);
      check_val("mid_rst_level", {27'd0, wr_level}, 32'd0);
      check_val("mid_rst_err", {31'd0, wr_err}, 32'd0);
      w_rst = 1'b0;
      w_en  = 1'b0;
      w_rb  = 0;

      // Read side: remote write pointer at 3, then three pops and one blocked pop.
      r_rst = 1'b0;
      r_rb  = 3;
      tick();
      tick();
      check_val("rd_flag_e2", {31'd0, rd_flag}, 32'd1);
      tick();
      check_val("rd_flag_e3", {31'd0, rd_flag}, 32'd0);
      check_val("rd_level_3", {27'd0, rd_level}, 32'd3);
      check_val("rd_almost_3", {31'd0, rd_almost}, 32'd0);
      r_en = 1'b1;
      tick();
      check_val("pop1_almost", {31'd0, rd_almost}, 32'd1);
      check_val("pop1_level", {27'd0, rd_level}, 32'd2);
      check_val("pop1_flag", {31'd0, rd_flag}, 32'd0);
      tick();
      tick();
      check_val("pop3_flag", {31'd0, rd_flag}, 32'd1);
      check_val("pop3_level", {27'd0, rd_level}, 32'd0);
      tick();
      check_val("pop4_err", {31'd0, rd_err}, 32'd1);
      check_val("pop4_bin_ptr", {28'd0, rd_bptr}, 32'd3);
      r_en = 1'b0;

      // Wrap: 40 writes with the remote pointer following the local one.
      w_en = 1'b1;
      prev_gray = wr_gray;
      prev_bptr = wr_bptr;
      for (int i = 1; i <= 40; i++) begin
         w_rb = m_bin[0];
         tick();
         check_val("wrap_hamming", $countones(prev_gray ^ wr_gray), 32'd1);
         if (i % 16 == 0) begin
            check_val("wrap_bptr_prev", {28'd0, prev_bptr}, 32'd15);
            check_val("wrap_bptr_now", {28'd0, wr_bptr}, 32'd0);
         end
         if (i == 32) begin
            check_val("wrap32_gray_prev", {27'd0, prev_gray}, 32'b10000);
            check_val("wrap32_gray_now", {27'd0, wr_gray}, 32'b00000);
         end
         prev_gray = wr_gray;
         prev_bptr = wr_bptr;
      end
      w_en = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
